cheat_pgm_sequencer: RTL and testbench

- Shadows the cheat table written byte-wise by the MCU: six address/data slots, the ROM-patch enable mask, and the global enable/hook flag byte.
- On a commit strobe, replays the table into the cheat unit's pgm_idx/pgm_we/pgm_in programming port as an ordered burst.
- The burst is aligned to an SNES cycle start, and cheat_enable is cleared first, so a half-written table is never live on the bus.
- Sits between the MCU register interface and the cheat unit, in the sd2snes top level.

---
 rtl/cheat_pgm_pkg.sv | 48 ++++
 rtl/cheat_pgm_sequencer_prio_enc.sv | 20 ++
 rtl/cheat_pgm_sequencer.sv | 224 ++++++++++++++++++++++
 tb/tb_cheat_pgm_sequencer.sv | 395 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cheat_pgm_pkg.sv
// Shared types and constants for the cheat-table programming sequencer.
package cheat_pgm_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_SYNC = 3'd1,
    DISABLE   = 3'd2,
    LOAD      = 3'd3,
    MASK      = 3'd4,
    ENABLE    = 3'd5,
    DONE      = 3'd6
  } state_e;

  localparam logic [2:0]  PGM_IDX_MASK  = 3'd6;
  localparam logic [2:0]  PGM_IDX_FLAGS = 3'd7;
  localparam logic [31:0] DISABLE_WORD  = 32'h0000_0010;
  localparam logic [4:0]  ADDR_MASK     = 5'd24;
  localparam logic [4:0]  ADDR_FLAGS    = 5'd25;
  localparam logic [4:0]  ADDR_DIRTY    = 5'd26;

  // Byte lane 0 is the top address byte, lane 3 is the data byte.
  function automatic logic [31:0] put_byte(input logic [31:0] word,
                                           input logic [1:0]  lane,
                                           input logic [7:0]  value);
    logic [31:0] res;
    res = word;
    case (lane)
      2'd0:    res[31:24] = value;
      2'd1:    res[23:16] = value;
      2'd2:    res[15:8]  = value;
      default: res[7:0]   = value;
    endcase
    return res;
  endfunction

  function automatic logic [7:0] get_byte(input logic [31:0] word,
                                          input logic [1:0]  lane);
    logic [7:0] res;
    case (lane)
      2'd0:    res = word[31:24];
      2'd1:    res = word[23:16];
      2'd2:    res = word[15:8];
      default: res = word[7:0];
    endcase
    return res;
  endfunction

endpackage

// File: rtl/cheat_pgm_sequencer_prio_enc.sv
// Lowest-index-first priority encoder over the slot dirty bits.
module cheat_pgm_prio_enc #(
  parameter int N  = 6,
  parameter int IW = 3
) (
  input  logic [N-1:0]  vec_i,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  // Walk downwards so the lowest set bit wins the last assignment.
  always_comb begin
    idx_o = '0;
    for (int i = N - 1; i >= 0; i--) begin
      idx_o = vec_i[i] ? IW'(i) : idx_o;
    end
    any_o = |vec_i;
  end

endmodule

// File: rtl/cheat_pgm_sequencer.sv
// Shadows the MCU cheat table and replays it to the cheat unit as one burst.
// Optional shadow readback port enabled by defining CHEAT_PGM_READBACK_EN.
module cheat_pgm_sequencer
  import cheat_pgm_pkg::*;
#(
  parameter int SLOTS        = 6,
  parameter int SYNC_TIMEOUT = 1023
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mcu_we,
  input  logic [4:0]  mcu_addr,
  input  logic [7:0]  mcu_data,
  input  logic        commit,
  input  logic        snes_cycle_start,
  output logic [2:0]  pgm_idx,
  output logic        pgm_we,
  output logic [31:0] pgm_in,
  output logic        busy,
  output logic        done,
  output logic        wr_reject
`ifdef CHEAT_PGM_READBACK_EN
  ,
  output logic [7:0]  mcu_rdata
`endif
);

  localparam int IW = 3;
  localparam int CW = $clog2(SYNC_TIMEOUT + 1);
  localparam logic [CW-1:0] TMO = CW'(SYNC_TIMEOUT);

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [31:0]       slot_q [SLOTS];
  logic [31:0]       slot_d [SLOTS];
  logic [5:0]        mask_q, mask_d;
  logic [7:0]        flags_q, flags_d;
  logic [SLOTS-1:0]  dirty_q, dirty_d;
  logic [2:0]        pgm_idx_q, pgm_idx_d;
  logic              pgm_we_q, pgm_we_d;
  logic [31:0]       pgm_in_q, pgm_in_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              wr_reject_q, wr_reject_d;

  logic              wr_ok_s;
  logic [IW-1:0]     wr_slot_s;
  logic [1:0]        wr_lane_s;
  logic [SLOTS-1:0]  set_s, clr_s;
  logic [IW-1:0]     enc_idx_s;
  logic              enc_any_s;
  logic [31:0]       sel_word_s;

  assign wr_ok_s   = mcu_we & ~busy_q;
  assign wr_slot_s = mcu_addr[4:2];
  assign wr_lane_s = mcu_addr[1:0];

  cheat_pgm_prio_enc #(
    .N  (SLOTS),
    .IW (IW)
  ) u_prio_enc (
    .vec_i (dirty_q),
    .idx_o (enc_idx_s),
    .any_o (enc_any_s)
  );

  // Slot word selected by the priority encoder for the next LOAD write.
  always_comb begin
    sel_word_s = 32'h0000_0000;
    for (int s = 0; s < SLOTS; s++) begin
      sel_word_s = (enc_idx_s == IW'(s)) ? slot_q[s] : sel_word_s;
    end
  end

  // Shadow table update from accepted MCU writes; dirty bits cleared as slots are replayed.
  always_comb begin
    mask_d  = mask_q;
    flags_d = flags_q;
    set_s   = '0;
    for (int s = 0; s < SLOTS; s++) begin
      if (wr_ok_s && (mcu_addr < ADDR_MASK) && (wr_slot_s == IW'(s))) begin
        slot_d[s] = put_byte(slot_q[s], wr_lane_s, mcu_data);
        set_s[s]  = 1'b1;
      end else begin
        slot_d[s] = slot_q[s];
      end
    end
    if (wr_ok_s && (mcu_addr == ADDR_MASK)) begin
      mask_d = mcu_data[5:0];
    end else if (wr_ok_s && (mcu_addr == ADDR_FLAGS)) begin
      flags_d = mcu_data;
    end else begin
      mask_d = mask_q;
    end
    dirty_d = (dirty_q | set_s) & ~clr_s;
  end

  // Sequencer next state; outputs are computed for the state being entered so they appear registered.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pgm_we_d  = 1'b0;
    pgm_idx_d = 3'd0;
    pgm_in_d  = 32'h0000_0000;
    clr_s     = '0;
    case (state_q)
      IDLE: begin
        if (commit) begin
          state_d = WAIT_SYNC;
          cnt_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end
      WAIT_SYNC: begin
        cnt_d = (cnt_q == TMO) ? cnt_q : cnt_q + CW'(1);
        if (snes_cycle_start || (cnt_d == TMO)) begin
          state_d   = DISABLE;
          pgm_we_d  = 1'b1;
          pgm_idx_d = PGM_IDX_FLAGS;
          pgm_in_d  = DISABLE_WORD;
        end else begin
          state_d = WAIT_SYNC;
        end
      end
      DISABLE, LOAD: begin
        if (enc_any_s) begin
          state_d   = LOAD;
          pgm_we_d  = 1'b1;
          pgm_idx_d = enc_idx_s;
          pgm_in_d  = sel_word_s;
          for (int s = 0; s < SLOTS; s++) begin
            clr_s[s] = (enc_idx_s == IW'(s));
          end
        end else begin
          state_d   = MASK;
          pgm_we_d  = 1'b1;
          pgm_idx_d = PGM_IDX_MASK;
          pgm_in_d  = {26'b0, mask_q};
        end
      end
      MASK: begin
        state_d   = ENABLE;
        pgm_we_d  = 1'b1;
        pgm_idx_d = PGM_IDX_FLAGS;
        pgm_in_d  = {24'b0, flags_q};
      end
      ENABLE: begin
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d      = (state_d != IDLE);
    done_d      = (state_d == DONE);
    wr_reject_d = busy_q & (mcu_we | commit);
  end

  // All state and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      slot_q      <= '{default: 32'h0000_0000};
      mask_q      <= 6'd0;
      flags_q     <= 8'd0;
      dirty_q     <= '0;
      pgm_idx_q   <= 3'd0;
      pgm_we_q    <= 1'b0;
      pgm_in_q    <= 32'h0000_0000;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      wr_reject_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      slot_q      <= slot_d;
      mask_q      <= mask_d;
      flags_q     <= flags_d;
      dirty_q     <= dirty_d;
      pgm_idx_q   <= pgm_idx_d;
      pgm_we_q    <= pgm_we_d;
      pgm_in_q    <= pgm_in_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      wr_reject_q <= wr_reject_d;
    end
  end

  assign pgm_idx   = pgm_idx_q;
  assign pgm_we    = pgm_we_q;
  assign pgm_in    = pgm_in_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign wr_reject = wr_reject_q;

`ifdef CHEAT_PGM_READBACK_EN
  logic [7:0] rd_s;

  // Combinational readback of the shadow byte at mcu_addr.
  always_comb begin
    rd_s = 8'h00;
    if (mcu_addr == ADDR_MASK) begin
      rd_s = {2'b00, mask_q};
    end else if (mcu_addr == ADDR_FLAGS) begin
      rd_s = flags_q;
    end else if (mcu_addr == ADDR_DIRTY) begin
      rd_s[SLOTS-1:0] = dirty_q;
    end else begin
      for (int s = 0; s < SLOTS; s++) begin
        rd_s = ((mcu_addr < ADDR_MASK) && (wr_slot_s == IW'(s))) ?
               get_byte(slot_q[s], wr_lane_s) : rd_s;
      end
    end
  end

  assign mcu_rdata = rd_s;
`endif

endmodule

// File: tb/tb_cheat_pgm_sequencer.sv
// Randomised bench for cheat_pgm_sequencer against a table-level model of the burst.
module tb_cheat_pgm_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mcu_we = 1'b0;
  logic [4:0]  mcu_addr = 5'd0;
  logic [7:0]  mcu_data = 8'd0;
  logic        commit = 1'b0;
  logic        snes = 1'b0;
  logic [2:0]  pgm_idx;
  logic        pgm_we;
  logic [31:0] pgm_in;
  logic        busy, done, wr_reject;
`ifdef CHEAT_PGM_READBACK_EN
  logic [7:0]  mcu_rdata;
`endif

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  cheat_pgm_sequencer dut (
    .clk(clk), .rst_n(rst_n), .mcu_we(mcu_we), .mcu_addr(mcu_addr),
    .mcu_data(mcu_data), .commit(commit), .snes_cycle_start(snes),
    .pgm_idx(pgm_idx), .pgm_we(pgm_we), .pgm_in(pgm_in),
    .busy(busy), .done(done), .wr_reject(wr_reject)
`ifdef CHEAT_PGM_READBACK_EN
    , .mcu_rdata(mcu_rdata)
`endif
  );

  // Reference table and burst queues.
  logic [31:0] m_slot [6];
  logic [5:0]  m_mask;
  logic [7:0]  m_flags;
  logic [5:0]  m_dirty;
  logic [2:0]  e_idx[$];
  logic [31:0] e_word[$];
  logic [2:0]  c_idx[$];
  logic [31:0] c_word[$];
  int          c_cyc[$];

  // Capture every programming write; idle bus must read zero.
  always @(negedge clk) begin
    if (rst_n) begin
      if (pgm_we) begin
        c_idx.push_back(pgm_idx);
        c_word.push_back(pgm_in);
        c_cyc.push_back(cyc);
      end else begin
        vectors++;
        if (pgm_idx !== 3'd0 || pgm_in !== 32'd0) begin
          miscompares++;
          $display("FAIL idle_bus: idx=%0d in=%h, required 0 and 0", pgm_idx, pgm_in);
        end
      end
    end
  end

  task automatic m_reset();
    for (int i = 0; i < 6; i++) m_slot[i] = 32'd0;
    m_mask = 6'd0; m_flags = 8'd0; m_dirty = 6'd0;
  endtask

  task automatic m_write(input logic [4:0] a, input logic [7:0] d);
    int s, b;
    s = int'(a[4:2]);
    b = int'(a[1:0]);
    if (a == 5'd24) m_mask = d[5:0];
    else if (a == 5'd25) m_flags = d;
    else if (a < 5'd24) begin
      m_slot[s][(31 - 8 * b) -: 8] = d;
      m_dirty[s] = 1'b1;
    end
  endtask

  task automatic m_commit();
    e_idx.delete(); e_word.delete();
    e_idx.push_back(3'd7); e_word.push_back(32'h10);
    for (int s = 0; s < 6; s++) begin
      if (m_dirty[s]) begin
        e_idx.push_back(3'(s)); e_word.push_back(m_slot[s]);
      end
    end
    m_dirty = 6'd0;
    e_idx.push_back(3'd6); e_word.push_back({26'b0, m_mask});
    e_idx.push_back(3'd7); e_word.push_back({24'b0, m_flags});
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic clear_cap();
    c_idx.delete(); c_word.delete(); c_cyc.delete();
  endtask

  task automatic wr(input logic [4:0] a, input logic [7:0] d);
    mcu_we = 1'b1; mcu_addr = a; mcu_data = d;
    step();
    mcu_we = 1'b0;
    m_write(a, d);
  endtask

  task automatic do_commit();
    clear_cap();
    commit = 1'b1;
    step();
    commit = 1'b0;
    m_commit();
  endtask

  task automatic wr_commit(input logic [4:0] a, input logic [7:0] d);
    clear_cap();
    mcu_we = 1'b1; mcu_addr = a; mcu_data = d; commit = 1'b1;
    step();
    mcu_we = 1'b0; commit = 1'b0;
    m_write(a, d);
    m_commit();
  endtask

  task automatic pulse_sync(output int sc);
    snes = 1'b1;
    step();
    snes = 1'b0;
    sc = cyc;
  endtask

  task automatic wait_done(output int dc);
    dc = -1;
    for (int n = 0; n < 3000; n++) begin
      step();
      if (done) begin
        dc = cyc;
        break;
      end
    end
    if (dc < 0) begin
      vectors++; miscompares++;
      $display("FAIL done_timeout: done not seen within 3000 clocks, required a done pulse");
    end
  endtask

  task automatic test_reset();
    #3;
    vectors++;
    if ({pgm_idx, pgm_we, pgm_in, busy, done, wr_reject} !== 39'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: idx=%0d we=%b in=%h busy=%b done=%b rej=%b, required all 0",
               pgm_idx, pgm_we, pgm_in, busy, done, wr_reject);
    end
    #10 rst_n = 1'b1;
    step();
    vectors++;
    if (busy !== 1'b0 || pgm_we !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_release: busy=%b we=%b, required 0 0", busy, pgm_we);
    end
    m_reset();
  endtask

  task automatic test_basic();
    int sc, dc;
    wr(5'd0, 8'h7E); wr(5'd1, 8'h00); wr(5'd2, 8'h10); wr(5'd3, 8'h63); wr(5'd25, 8'h01);
    do_commit();
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++; $display("FAIL basic_busy: busy=%b, required 1", busy);
    end
    repeat (4) step();
    pulse_sync(sc);
    wait_done(dc);
    vectors++;
    if (c_idx.size() != 4 || c_word[1] !== 32'h7E00_1063) begin
      miscompares++;
      $display("FAIL basic_slot0: writes=%0d word=%h, required 4 and 7e001063", c_idx.size(), c_word[1]);
    end
    vectors++;
    if (c_idx.size() != e_idx.size()) begin
      miscompares++; $display("FAIL basic_len: %0d writes, required %0d", c_idx.size(), e_idx.size());
    end
    for (int i = 0; i < e_idx.size() && i < c_idx.size(); i++) begin
      vectors++;
      if (c_idx[i] !== e_idx[i] || c_word[i] !== e_word[i] || c_cyc[i] != sc + i) begin
        miscompares++;
        $display("FAIL basic_wr%0d: idx=%0d in=%h cyc=%0d, required idx=%0d in=%h cyc=%0d",
                 i, c_idx[i], c_word[i], c_cyc[i], e_idx[i], e_word[i], sc + i);
      end
    end
    vectors++;
    if (dc != sc + e_idx.size()) begin
      miscompares++; $display("FAIL basic_done: cyc=%0d, required %0d", dc, sc + e_idx.size());
    end
    step();
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++; $display("FAIL basic_idle: busy=%b, required 0", busy);
    end
  endtask

  task automatic test_two_slots();
    int sc, dc;
    for (int b = 0; b < 4; b++) begin
      wr(5'(4 + b), 8'($urandom));
      wr(5'(16 + b), 8'($urandom));
    end
    wr(5'd24, 8'($urandom)); wr(5'd25, 8'($urandom));
    do_commit();
    repeat ($urandom_range(1, 20)) step();
    pulse_sync(sc);
    wait_done(dc);
    vectors++;
    if (c_idx.size() != 5 || e_idx.size() != 5) begin
      miscompares++; $display("FAIL two_len: %0d writes, required 5", c_idx.size());
    end
    for (int i = 0; i < e_idx.size() && i < c_idx.size(); i++) begin
      vectors++;
      if (c_idx[i] !== e_idx[i] || c_word[i] !== e_word[i] || c_cyc[i] != sc + i) begin
        miscompares++;
        $display("FAIL two_wr%0d: idx=%0d in=%h cyc=%0d, required idx=%0d in=%h cyc=%0d",
                 i, c_idx[i], c_word[i], c_cyc[i], e_idx[i], e_word[i], sc + i);
      end
    end
    step();
  endtask

  task automatic test_timeout();
    int cc, dc;
    wr(5'd23, 8'($urandom));
    do_commit();
    cc = cyc;
    wait_done(dc);
    vectors++;
    if (c_idx.size() != e_idx.size()) begin
      miscompares++; $display("FAIL tmo_len: %0d writes, required %0d", c_idx.size(), e_idx.size());
    end
    for (int i = 0; i < e_idx.size() && i < c_idx.size(); i++) begin
      vectors++;
      if (c_idx[i] !== e_idx[i] || c_word[i] !== e_word[i] || c_cyc[i] != cc + 1023 + i) begin
        miscompares++;
        $display("FAIL tmo_wr%0d: idx=%0d in=%h cyc=%0d, required idx=%0d in=%h cyc=%0d",
                 i, c_idx[i], c_word[i], c_cyc[i], e_idx[i], e_word[i], cc + 1023 + i);
      end
    end
    step();
  endtask

  task automatic test_reject();
    int sc, dc;
    for (int a = 0; a < 12; a++) wr(5'(a), 8'($urandom));
    do_commit();
    pulse_sync(sc);
    step();
    mcu_we = 1'b1; mcu_addr = 5'd2; mcu_data = ~m_slot[0][15:8];
    step();
    mcu_we = 1'b0;
    vectors++;
    if (wr_reject !== 1'b1) begin
      miscompares++; $display("FAIL rej_we: wr_reject=%b, required 1", wr_reject);
    end
    step();
    vectors++;
    if (wr_reject !== 1'b0) begin
      miscompares++; $display("FAIL rej_pulse: wr_reject=%b, required 0", wr_reject);
    end
    wait_done(dc);
    for (int i = 0; i < e_idx.size() && i < c_idx.size(); i++) begin
      vectors++;
      if (c_idx[i] !== e_idx[i] || c_word[i] !== e_word[i] || c_cyc[i] != sc + i) begin
        miscompares++;
        $display("FAIL rej_wr%0d: idx=%0d in=%h, required idx=%0d in=%h", i, c_idx[i], c_word[i], e_idx[i], e_word[i]);
      end
    end
    step();
    do_commit();
    pulse_sync(sc);
    wait_done(dc);
    vectors++;
    if (c_idx.size() != 3) begin
      miscompares++; $display("FAIL rej_dirty: %0d writes, required 3", c_idx.size());
    end
    step();
    wr(5'd3, 8'($urandom));
    do_commit();
    pulse_sync(sc);
    wait_done(dc);
    vectors++;
    if (c_idx.size() != 4 || c_word[1] !== e_word[1]) begin
      miscompares++;
      $display("FAIL rej_shadow: %0d writes slot0=%h, required 4 and %h", c_idx.size(), c_word[1], e_word[1]);
    end
    step();
  endtask

  task automatic test_reset_mid();
    int sc, dc;
    for (int b = 8; b < 16; b++) wr(5'(b), 8'($urandom));
    do_commit();
    pulse_sync(sc);
    step();
    vectors++;
    if (pgm_we !== 1'b1 || pgm_idx !== 3'd2) begin
      miscompares++; $display("FAIL rst_pre: we=%b idx=%0d, required 1 and 2", pgm_we, pgm_idx);
    end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({pgm_idx, pgm_we, pgm_in, busy, done, wr_reject} !== 39'd0) begin
      miscompares++;
      $display("FAIL rst_async: idx=%0d we=%b in=%h busy=%b, required all 0", pgm_idx, pgm_we, pgm_in, busy);
    end
    m_reset();
    clear_cap();
    #3 rst_n = 1'b1;
    repeat (10) step();
    vectors++;
    if (c_idx.size() != 0) begin
      miscompares++; $display("FAIL rst_quiet: %0d writes after reset, required 0", c_idx.size());
    end
    do_commit();
    pulse_sync(sc);
    wait_done(dc);
    vectors++;
    if (c_idx.size() != 3) begin
      miscompares++; $display("FAIL rst_len: %0d writes, required 3", c_idx.size());
    end
    for (int i = 0; i < e_idx.size() && i < c_idx.size(); i++) begin
      vectors++;
      if (c_idx[i] !== e_idx[i] || c_word[i] !== e_word[i] || c_cyc[i] != sc + i) begin
        miscompares++;
        $display("FAIL rst_wr%0d: idx=%0d in=%h, required idx=%0d in=%h", i, c_idx[i], c_word[i], e_idx[i], e_word[i]);
      end
    end
    step();
  endtask

  task automatic test_mask_commit();
    int sc, dc;
    wr_commit(5'd24, 8'hFF);
    repeat (3) step();
    pulse_sync(sc);
    wait_done(dc);
    vectors++;
    if (c_idx.size() != 3 || c_idx[1] !== 3'd6 || c_word[1] !== 32'h3F) begin
      miscompares++;
      $display("FAIL mask_commit: %0d writes idx=%0d in=%h, required 3 6 0000003f", c_idx.size(), c_idx[1], c_word[1]);
    end
    step();
  endtask

  task automatic test_random();
    int sc, dc;
    for (int it = 0; it < 6; it++) begin
      repeat ($urandom_range(1, 10)) wr(5'($urandom_range(0, 31)), 8'($urandom));
      if ($urandom_range(0, 1) == 1) wr_commit(5'($urandom_range(0, 31)), 8'($urandom));
      else do_commit();
      repeat ($urandom_range(0, 8)) step();
      pulse_sync(sc);
      wait_done(dc);
      vectors++;
      if (c_idx.size() != e_idx.size() || dc != sc + e_idx.size()) begin
        miscompares++;
        $display("FAIL rnd%0d_len: %0d writes done=%0d, required %0d and %0d",
                 it, c_idx.size(), dc, e_idx.size(), sc + e_idx.size());
      end
      for (int i = 0; i < e_idx.size() && i < c_idx.size(); i++) begin
        vectors++;
        if (c_idx[i] !== e_idx[i] || c_word[i] !== e_word[i] || c_cyc[i] != sc + i) begin
          miscompares++;
          $display("FAIL rnd%0d_wr%0d: idx=%0d in=%h cyc=%0d, required idx=%0d in=%h cyc=%0d",
                   it, i, c_idx[i], c_word[i], c_cyc[i], e_idx[i], e_word[i], sc + i);
        end
      end
      step();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_two_slots();
    test_timeout();
    test_reject();
    test_reset_mid();
    test_mask_commit();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
